// File: rtl/rf_multiport.sv
// Multiported RV32I integer register file: NUM_RD combinational reads, NUM_WR writes,
// hard-wired x0 and a per-register busy scoreboard. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rf_multiport #(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32,
  parameter int ADDR_W   = $clog2(RF_DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     sb_set_en_i,
  input  logic [ADDR_W-1:0]        sb_set_addr_i
);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("rf_multiport: NUM_RD must be in 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
    $error("rf_multiport: NUM_WR must be in 1..2");
  end
  if (RF_DEPTH < 2 || (RF_DEPTH & (RF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_multiport: RF_DEPTH must be a power of 2 and >= 2");
  end

  logic [XLEN-1:0]     regs_q [RF_DEPTH];
  logic [XLEN-1:0]     regs_d [RF_DEPTH];
  logic [RF_DEPTH-1:0] busy_q;
  logic [RF_DEPTH-1:0] busy_d;

  // Ports are applied in ascending order so the highest-index write port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k]) begin
        regs_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = wr_data_i[k*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // A set is applied after all clears: a newly issued producer outranks a completing one.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k]) begin
        busy_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (sb_set_en_i) begin
      busy_d[sb_set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Outputs are forced low while reset is asserted so forwarded write data cannot leak out.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    if (rst_n) begin
      for (int i = 0; i < NUM_RD; i++) begin
`ifdef RF_BYPASS_EN
        rd_data_o[i*XLEN +: XLEN] = regs_d[rd_addr_i[i*ADDR_W +: ADDR_W]];
        rd_busy_o[i]              = busy_d[rd_addr_i[i*ADDR_W +: ADDR_W]];
`else
        rd_data_o[i*XLEN +: XLEN] = regs_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
        rd_busy_o[i]              = busy_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (NUM_RD=4, NUM_WR=2); expectations
// follow RF_BYPASS_EN when the bench is built with that macro.
module tb_rf_multiport;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 4;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                sb_set_en = 1'b0;
  logic [AW-1:0]       sb_set_addr = '0;

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  rf_multiport #(
    .XLEN(XLEN), .RF_DEPTH(32), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .rd_busy_o(rd_busy),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .sb_set_en_i(sb_set_en),
    .sb_set_addr_i(sb_set_addr)
  );

  function automatic logic [XLEN-1:0] rdd(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  // Driver tasks
  task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic drive_set(input logic [AW-1:0] a);
    sb_set_en   = 1'b1;
    sb_set_addr = a;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // Advance past one rising edge, then drop the write/issue strobes.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en     = '0;
    sb_set_en = 1'b0;
  endtask

  task automatic test_reset();
    set_rd(0, 5'd3);
    drive_wr(0, 5'd3, 32'h1234_5678);
    #12;
    for (int p = 0; p < NRD; p++) begin
      total++;
      if (rdd(p) !== 32'h0) begin
        bad++; $display("FAIL reset_data port%0d: got %h want %h", p, rdd(p), 32'h0);
      end
      total++;
      if (rd_busy[p] !== 1'b0) begin
        bad++; $display("FAIL reset_busy port%0d: got %b want 0", p, rd_busy[p]);
      end
    end
    wr_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_midstream();
    drive_wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    drive_set(5'd5);
    step();
    set_rd(0, 5'd5);
    #1;
    total++;
    if (rdd(0) !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL pre_reset_data: got %h want %h", rdd(0), 32'hDEAD_BEEF);
    end
    total++;
    if (rd_busy[0] !== 1'b1) begin
      bad++; $display("FAIL pre_reset_busy: got %b want 1", rd_busy[0]);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++; $display("FAIL midreset_data: got %h want %h", rdd(0), 32'h0);
    end
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL midreset_busy: got %b want 0", rd_busy[0]);
    end
    #1 rst_n = 1'b1;
    step();
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++; $display("FAIL post_reset_data: got %h want %h", rdd(0), 32'h0);
    end
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL post_reset_busy: got %b want 0", rd_busy[0]);
    end
  endtask

  task automatic test_x0();
    set_rd(1, 5'd0);
    drive_wr(0, 5'd0, 32'hFFFF_FFFF);
    drive_wr(1, 5'd0, 32'hFFFF_FFFF);
    drive_set(5'd0);
    #1;
    total++;
    if (rdd(1) !== 32'h0) begin
      bad++; $display("FAIL x0_same_cycle_data: got %h want %h", rdd(1), 32'h0);
    end
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++; $display("FAIL x0_same_cycle_busy: got %b want 0", rd_busy[1]);
    end
    step();
    total++;
    if (rdd(1) !== 32'h0) begin
      bad++; $display("FAIL x0_data: got %h want %h", rdd(1), 32'h0);
    end
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++; $display("FAIL x0_busy: got %b want 0", rd_busy[1]);
    end
  endtask

  task automatic test_collision();
    logic [XLEN-1:0] exp;
    set_rd(2, 5'd7);
    drive_wr(0, 5'd7, 32'h1111_1111);
    drive_wr(1, 5'd7, 32'h2222_2222);
    #1;
`ifdef RF_BYPASS_EN
    exp = 32'h2222_2222;
`else
    exp = 32'h0;
`endif
    total++;
    if (rdd(2) !== exp) begin
      bad++; $display("FAIL collision_same_cycle: got %h want %h", rdd(2), exp);
    end
    step();
    total++;
    if (rdd(2) !== 32'h2222_2222) begin
      bad++; $display("FAIL collision: got %h want %h", rdd(2), 32'h2222_2222);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    set_rd(3, 5'd9);
    drive_set(5'd9);
    step();
    total++;
    if (rd_busy[3] !== 1'b1) begin
      bad++; $display("FAIL sb_set: got %b want 1", rd_busy[3]);
    end
    // WAW re-issue while already busy
    drive_set(5'd9);
    step();
    total++;
    if (rd_busy[3] !== 1'b1) begin
      bad++; $display("FAIL sb_waw: got %b want 1", rd_busy[3]);
    end
    drive_set(5'd9);
    drive_wr(0, 5'd9, 32'h55);
    #1;
    total++;
    if (rd_busy[3] !== 1'b1) begin
      bad++; $display("FAIL sb_race_same_cycle: got %b want 1", rd_busy[3]);
    end
    step();
    total++;
    if (rd_busy[3] !== 1'b1) begin
      bad++; $display("FAIL sb_race: got %b want 1", rd_busy[3]);
    end
    total++;
    if (rdd(3) !== 32'h55) begin
      bad++; $display("FAIL sb_race_data: got %h want %h", rdd(3), 32'h55);
    end
    drive_wr(0, 5'd9, 32'h66);
    #1;
`ifdef RF_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    total++;
    if (rd_busy[3] !== exp_b) begin
      bad++; $display("FAIL sb_clear_same_cycle: got %b want %b", rd_busy[3], exp_b);
    end
    step();
    total++;
    if (rd_busy[3] !== 1'b0) begin
      bad++; $display("FAIL sb_clear: got %b want 0", rd_busy[3]);
    end
    // Clear through write port 1
    set_rd(3, 5'd10);
    drive_set(5'd10);
    step();
    drive_wr(1, 5'd10, 32'h77);
    step();
    total++;
    if (rd_busy[3] !== 1'b0) begin
      bad++; $display("FAIL sb_clear_port1: got %b want 0", rd_busy[3]);
    end
    total++;
    if (rdd(3) !== 32'h77) begin
      bad++; $display("FAIL wr_port1_data: got %h want %h", rdd(3), 32'h77);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp;
    set_rd(2, 5'd3);
    drive_wr(0, 5'd3, 32'h1234_5678);
    step();
    drive_wr(0, 5'd3, 32'hAAAA_AAAA);
    #1;
`ifdef RF_BYPASS_EN
    exp = 32'hAAAA_AAAA;
`else
    exp = 32'h1234_5678;
`endif
    total++;
    if (rdd(2) !== exp) begin
      bad++; $display("FAIL bypass_same_cycle: got %h want %h", rdd(2), exp);
    end
    step();
    total++;
    if (rdd(2) !== 32'hAAAA_AAAA) begin
      bad++; $display("FAIL bypass_next_cycle: got %h want %h", rdd(2), 32'hAAAA_AAAA);
    end
  endtask

  task automatic test_sweep();
    logic [XLEN-1:0] exp;
    for (int n = 1; n < 32; n++) begin
      drive_wr(0, n[AW-1:0], n);
      step();
    end
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < NRD; p++) begin
        set_rd(p, a[AW-1:0]);
        exp_q.push_back(a);
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp = exp_q.pop_front();
        total++;
        if (rdd(p) !== exp) begin
          bad++; $display("FAIL sweep_data x%0d port%0d: got %h want %h", a, p, rdd(p), exp);
        end
        total++;
        if (rd_busy[p] !== 1'b0) begin
          bad++; $display("FAIL sweep_busy x%0d port%0d: got %b want 0", a, p, rd_busy[p]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_x0();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
